// File: rtl/spi_reg_port.sv
// spi_reg_port: addressed SPI command front-end writing and reading single config bytes.
// A command byte picks R/W and a start address; following bytes stream with auto-increment.
module spi_reg_port #(
    parameter int DW   = 8,
    parameter int NREG = 16
) (
    input  logic          spi_clk,
    input  logic          rst,
    input  logic          spi_csn,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          wr_en,
    output logic [DW-2:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [DW-2:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          addr_err,
    output logic          busy
);
    localparam int CW = $clog2(DW);
    typedef enum logic [1:0] {CMD, WDATA, RTURN, RDATA} state_t;
    state_t state, state_nx;
    logic [CW-1:0] bit_cnt;
    logic [DW-2:0] rx_shift;
    logic [DW-1:0] tx_reg;
    logic [DW-2:0] addr;
    logic frame_rst, byte_done, wr_hit, rd_hit, rd_load;
    // chip select high aborts the frame exactly like reset does
    assign frame_rst = rst | spi_csn;
    always_ff @(posedge spi_clk or posedge frame_rst)
        if (frame_rst) state <= CMD;
        else state <= state_nx;
    always_comb
        state_nx = !byte_done ? state :
                   state == CMD ? (wr_data[DW-1] ? RTURN : WDATA) :
                   state == RTURN ? RDATA : state;
    always_comb begin
        byte_done = bit_cnt == CW'(DW-1);
        wr_hit = 32'(addr) < NREG;
        rd_hit = 32'(rd_addr) < NREG;
        rd_load = byte_done && (state == RTURN || state == RDATA);
        wr_en = state == WDATA && byte_done && wr_hit;
        wr_addr = addr;
        wr_data = {rx_shift, spi_mosi};
        busy = state != CMD || bit_cnt != '0;
        spi_miso = tx_reg[DW-1];
    end
    always_ff @(posedge spi_clk or posedge frame_rst)
        if (frame_rst) begin
            bit_cnt <= '0;
            rx_shift <= '0;
            tx_reg <= '0;
        end else begin
            bit_cnt <= byte_done ? '0 : bit_cnt + 1'b1;
            rx_shift <= wr_data[DW-2:0];
            tx_reg <= rd_load ? (rd_hit ? rd_data : '0) : {tx_reg[DW-2:0], 1'b0};
        end
    // address pointers and the error flag survive chip-select aborts
    always_ff @(posedge spi_clk or posedge rst)
        if (rst) begin
            rd_addr <= '0;
            addr <= '0;
            addr_err <= 1'b0;
        end else if (!spi_csn) begin
            if (state == CMD && byte_done) begin
                if (wr_data[DW-1]) rd_addr <= wr_data[DW-2:0];
                else addr <= wr_data[DW-2:0];
            end
            if (state == WDATA && byte_done) begin
                addr <= addr + 1'b1;
                if (!wr_hit) addr_err <= 1'b1;
            end
            if (rd_load) begin
                rd_addr <= rd_addr + 1'b1;
                if (!rd_hit) addr_err <= 1'b1;
            end
        end
endmodule

// File: tb/tb_spi_reg_port.sv
// tb_spi_reg_port: drives SPI frames into two instances (NREG=16 and NREG=128)
// and checks strobes, MISO bytes, read pointer and error flag against a frame-level model.
module tb_spi_reg_port;
    logic spi_clk = 0, rst, spi_csn, spi_mosi;
    logic spi_miso, wr_en, addr_err, busy;
    logic [6:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;
    logic spi_miso2, wr_en2, addr_err2, busy2;
    logic [6:0] wr_addr2, rd_addr2;
    logic [7:0] wr_data2, rd_data2;
    logic [7:0] mem [128];
    logic [7:0] fr[$], miso_q[$], em[$];
    logic [22:0] wq0[$], wq1[$], ew[$];
    int n_cmp = 0, n_err = 0, edge_n;
    int m_err[2], m_rd[2];

    spi_reg_port #(.DW(8), .NREG(16)) dut (
        .spi_clk(spi_clk), .rst(rst), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .addr_err(addr_err), .busy(busy));
    spi_reg_port #(.DW(8), .NREG(128)) dut2 (
        .spi_clk(spi_clk), .rst(rst), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .addr_err(addr_err2), .busy(busy2));

    always #5 spi_clk = ~spi_clk;
    assign rd_data = mem[rd_addr];
    assign rd_data2 = mem[rd_addr2];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // entered and left at a falling edge; one bit per rising edge
    task send_byte(input logic [7:0] b, input int nbits, output logic [7:0] rx);
        rx = 0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            rx = {rx[6:0], spi_miso};
            spi_mosi = b[i];
            edge_n++;
            #1;
            if (wr_en) wq0.push_back({8'(edge_n), wr_addr, wr_data});
            if (wr_en2) wq1.push_back({8'(edge_n), wr_addr2, wr_data2});
            @(negedge spi_clk);
        end
    endtask

    task run_frame(input int partial);
        logic [7:0] rx;
        wq0.delete(); wq1.delete(); miso_q.delete(); edge_n = 0;
        @(negedge spi_clk);
        spi_csn = 0;
        foreach (fr[k]) begin
            send_byte(fr[k], 8, rx);
            miso_q.push_back(rx);
        end
        if (partial > 0) send_byte(8'($urandom), partial, rx);
        spi_csn = 1;
        #1;
    endtask

    // frame-level reference: expected strobes (edge, addr, data), MISO bytes, pointer and error state
    task model_frame(input int d, input int nreg);
        logic [6:0] a;
        ew.delete(); em.delete();
        a = fr[0][6:0];
        if (!fr[0][7]) begin
            for (int j = 1; j < fr.size(); j++) begin
                if (int'(a) < nreg) ew.push_back({8'(8 * (j + 1)), a, fr[j]});
                else m_err[d] = 1;
                a = a + 7'd1;
            end
            foreach (fr[j]) em.push_back(8'h00);
        end else begin
            em.push_back(8'h00);
            if (fr.size() > 1) em.push_back(8'h00);
            for (int j = 1; j < fr.size(); j++) begin
                if (j + 1 < fr.size()) em.push_back(int'(a) < nreg ? mem[a] : 8'h00);
                if (int'(a) >= nreg) m_err[d] = 1;
                a = a + 7'd1;
            end
            m_rd[d] = int'(a);
        end
    endtask

    task rand_frame(input logic rd, input int lo, input int hi, input int nb);
        fr.delete();
        fr.push_back({rd, 7'($urandom_range(lo, hi))});
        for (int j = 1; j < nb; j++) fr.push_back(8'($urandom));
    endtask

    task test_reset;
        rst = 0; spi_csn = 0; spi_mosi = 0;
        #2;
        rst = 1; spi_csn = 1;
        repeat (2) @(negedge spi_clk);
        rst = 0;
        #1;
        m_err = '{0, 0}; m_rd = '{0, 0};
        n_cmp += 5;
        if (spi_miso !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b exp 0", spi_miso); end
        if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b exp 0", wr_en); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
        if (addr_err !== 1'b0) begin n_err++; $display("FAIL reset_addr_err: got %b exp 0", addr_err); end
        if (rd_addr !== 7'd0) begin n_err++; $display("FAIL reset_rd_addr: got %0d exp 0", rd_addr); end
    endtask

    task test_write;
        for (int t = 0; t < 9; t++) begin
            if (t == 0) fr = '{8'h03, 8'hA5};
            else rand_frame(1'b0, 0, 12, $urandom_range(2, 4));
            run_frame(0);
            model_frame(0, 16);
            n_cmp += 3;
            if (wq0.size() != ew.size()) begin n_err++; $display("FAIL write_count: got %0d exp %0d", wq0.size(), ew.size()); end
            if (addr_err !== m_err[0][0]) begin n_err++; $display("FAIL write_addr_err: got %b exp %0d", addr_err, m_err[0]); end
            if (busy !== 1'b0) begin n_err++; $display("FAIL write_busy_end: got %b exp 0", busy); end
            foreach (ew[k]) begin
                n_cmp++;
                if (k >= wq0.size() || wq0[k] !== ew[k]) begin n_err++; $display("FAIL write_strobe: got %h exp %h (edge/addr/data)", k < wq0.size() ? wq0[k] : 23'h0, ew[k]); end
            end
        end
    endtask

    task test_overflow;
        fr = '{8'h0E, 8'h11, 8'h22, 8'h33};
        run_frame(0);
        model_frame(0, 16);
        n_cmp += 2;
        if (wq0.size() != 2 || ew.size() != 2) begin n_err++; $display("FAIL ovf_count: got %0d exp 2", wq0.size()); end
        if (addr_err !== 1'b1) begin n_err++; $display("FAIL ovf_addr_err: got %b exp 1", addr_err); end
        foreach (ew[k]) begin
            n_cmp++;
            if (k >= wq0.size() || wq0[k] !== ew[k]) begin n_err++; $display("FAIL ovf_strobe: got %h exp %h", k < wq0.size() ? wq0[k] : 23'h0, ew[k]); end
        end
    endtask

    task test_read;
        mem[5] = 8'h5A; mem[6] = 8'hC3;
        for (int t = 0; t < 7; t++) begin
            if (t == 0) fr = '{8'h85, 8'hFF, 8'h00, 8'hFF};
            else rand_frame(1'b1, 0, 20, $urandom_range(2, 5));
            run_frame(0);
            model_frame(0, 16);
            n_cmp += 4;
            if (wq0.size() != 0) begin n_err++; $display("FAIL read_no_strobe: got %0d exp 0", wq0.size()); end
            if (rd_addr !== 7'(m_rd[0])) begin n_err++; $display("FAIL read_rd_addr: got %0d exp %0d", rd_addr, m_rd[0]); end
            if (addr_err !== m_err[0][0]) begin n_err++; $display("FAIL read_addr_err: got %b exp %0d", addr_err, m_err[0]); end
            if (miso_q.size() != em.size()) begin n_err++; $display("FAIL read_len: got %0d exp %0d", miso_q.size(), em.size()); end
            foreach (em[k]) begin
                n_cmp++;
                if (k >= miso_q.size() || miso_q[k] !== em[k]) begin n_err++; $display("FAIL read_miso_byte%0d: got %h exp %h", k, k < miso_q.size() ? miso_q[k] : 8'h0, em[k]); end
            end
        end
    endtask

    task test_wrap;
        fr = '{8'h7F, 8'h01, 8'h02};
        run_frame(0);
        model_frame(0, 16);
        model_frame(1, 128);
        n_cmp++;
        if (wq1.size() != ew.size()) begin n_err++; $display("FAIL wrap_count: got %0d exp %0d", wq1.size(), ew.size()); end
        foreach (ew[k]) begin
            n_cmp++;
            if (k >= wq1.size() || wq1[k] !== ew[k]) begin n_err++; $display("FAIL wrap_strobe: got %h exp %h", k < wq1.size() ? wq1[k] : 23'h0, ew[k]); end
        end
    endtask

    task test_abort;
        fr = '{8'h04};
        run_frame(5);
        n_cmp++;
        if (wq0.size() != 0) begin n_err++; $display("FAIL abort_strobe: got %0d exp 0", wq0.size()); end
        fr = '{8'h02, 8'h77};
        run_frame(0);
        model_frame(0, 16);
        n_cmp++;
        if (wq0.size() != 1 || wq0[0] !== ew[0]) begin n_err++; $display("FAIL abort_next: got %0d strobes first %h exp %h", wq0.size(), wq0.size() > 0 ? wq0[0] : 23'h0, ew[0]); end
    endtask

    task test_reset_mid_read;
        logic [7:0] rx;
        mem[1] = 8'hFF;
        edge_n = 0;
        @(negedge spi_clk);
        spi_csn = 0;
        send_byte(8'h81, 8, rx);
        send_byte(8'h00, 8, rx);
        send_byte(8'h00, 1, rx);
        n_cmp++;
        if (spi_miso !== mem[1][6]) begin n_err++; $display("FAIL midread_miso: got %b exp %b", spi_miso, mem[1][6]); end
        rst = 1;
        #1;
        n_cmp += 4;
        if (spi_miso !== 1'b0) begin n_err++; $display("FAIL midread_rst_miso: got %b exp 0", spi_miso); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL midread_rst_busy: got %b exp 0", busy); end
        if (rd_addr !== 7'd0) begin n_err++; $display("FAIL midread_rst_rd_addr: got %0d exp 0", rd_addr); end
        if (addr_err !== 1'b0) begin n_err++; $display("FAIL midread_rst_addr_err: got %b exp 0", addr_err); end
        @(negedge spi_clk);
        rst = 0; spi_csn = 1;
        m_err = '{0, 0}; m_rd = '{0, 0};
        fr = '{8'h09, 8'h3C};
        run_frame(0);
        model_frame(0, 16);
        n_cmp++;
        if (wq0.size() != 1 || wq0[0] !== ew[0]) begin n_err++; $display("FAIL midread_next: got %0d strobes first %h exp %h", wq0.size(), wq0.size() > 0 ? wq0[0] : 23'h0, ew[0]); end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'($urandom);
        test_reset;
        test_write;
        test_overflow;
        test_read;
        test_wrap;
        test_abort;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_reg_port.md
Name: spi_reg_port

Overview:
- Addressed SPI command front-end that writes and reads individual configuration bytes.
- Decodes a command byte (R/W flag plus 7-bit address) followed by one or more data bytes.
- Drives a byte-wide write strobe interface and reads back through a byte-wide read port.
- Sits between the SPI pins and the configuration register bank, so single fields can be updated without reshifting the whole config vector.

Parameters:
DW, 8, byte width; command byte = 1 R/W bit + (DW-1) address bits.
NREG, 16, number of implemented register addresses; addresses >= NREG are out of range.

Ports:
spi_clk  input  1  SPI clock; all sampling on rising edge.
rst  input  1  asynchronous, active-high reset.
spi_csn  input  1  chip select, active low; high = frame abort/end, async frame reset.
spi_mosi  input  1  serial data in, MSB first.
spi_miso  output  1  serial data out = tx_reg[DW-1].
wr_en  output  1  combinational write strobe, valid for the current spi_clk rising edge.
wr_addr  output  DW-1  write address, combinational with wr_en.
wr_data  output  DW  write data = {rx_shift[DW-2:0], spi_mosi}.
rd_addr  output  DW-1  registered read address presented to the bank.
rd_data  input  DW  bank read data, combinational from rd_addr.
addr_err  output  1  sticky: out-of-range access seen; cleared only by rst.
busy  output  1  high while state != CMD or bit_cnt != 0.

Behaviour:
- Async frame reset when rst=1 or spi_csn=1:
  - state=CMD, bit_cnt=0, rx_shift=0, tx_reg=0.
  - spi_miso=0, wr_en=0, busy=0.
- rst additionally clears rd_addr=0, the internal address counter=0 and addr_err=0. spi_csn does not affect rd_addr, the address counter or addr_err.
- Bit sampling: on each rising spi_clk with csn low, shift rx_shift left with spi_mosi; bit_cnt increments 0..DW-1, then wraps to 0 ("byte-complete edge" = the edge where bit_cnt==DW-1).
- Except at byte-complete loads, tx_reg shifts left with 0 fill on every rising edge.
- States:
  - CMD: on byte-complete edge, decode cmd = {rx_shift[DW-2:0], spi_mosi}.
    - If cmd[DW-1]=0 → WDATA, addr <= cmd[DW-2:0].
    - If cmd[DW-1]=1 → RTURN, rd_addr <= cmd[DW-2:0].
  - WDATA: wr_en=1 exactly during the byte-complete edge when addr < NREG.
    - wr_addr = addr; addr increments on that edge.
    - If addr >= NREG: wr_en=0, addr_err <= 1, addr still increments.
  - RTURN: MISO outputs 0x00 for one turnaround byte.
    - On its byte-complete edge: tx_reg <= (rd_addr < NREG) ? rd_data : 0; addr_err <= 1 if out of range.
    - rd_addr increments; go to RDATA.
  - RDATA: MISO shifts out tx_reg MSB first. On each byte-complete edge, reload tx_reg by the same rule and increment rd_addr. Mosi data is ignored.
- Address arithmetic is modulo 2^(DW-1); 127 wraps to 0 for DW=8.
- Partial byte at CSn rise: discarded, no write strobe; the next frame starts with a command byte.
- Frame ending after the command byte only: no write, no side effect except the rd_addr/addr update.
- Downstream bank samples wr_en/wr_addr/wr_data on the same spi_clk rising edge; no latency beyond that edge.
- wr_en is never asserted in CMD, RTURN or RDATA states.

Test Plan:
- rst pulse → spi_miso=0, wr_en=0, busy=0, addr_err=0, rd_addr=0.
- Frame 0x03,0xA5 → single wr_en on 16th edge with wr_addr=3, wr_data=0xA5; no other strobes.
- Frame 0x0E,0x11,0x22,0x33 → strobes at addr 14,15 with data 0x11,0x22; addr 16 write suppressed; addr_err=1.
- Bank preloaded with reg5=0x5A, reg6=0xC3; frame 0x85, dummy, dummy, dummy → MISO bytes 0x00,0x5A,0xC3; no wr_en.
- Frame 0x7F,0x01,0x02 with NREG=128 → writes at addr 127 then 0 (wrap).
- Write frame with CSn raised after 5 data bits, then a new frame 0x02,0x77 → no strobe from the aborted byte; single wr_en at addr 2 with 0x77.
- Assert rst mid-read → MISO=0 immediately; next frame decodes its command correctly.
